// File: rtl/mem_initiator.sv
// Initiator side of the tiny8 single-port memory interface: takes one request
// at a time, drives the memory strobes until mem_resp or timeout, then pulses a response.
module mem_initiator #(
  parameter int WORD_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [WORD_WIDTH-1:0] req_addr,
  input  logic [WORD_WIDTH-1:0] req_wdata,
  output logic                  req_ready,
  output logic                  rsp_valid,
  output logic                  rsp_error,
  output logic [WORD_WIDTH-1:0] rsp_rdata,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [WORD_WIDTH-1:0] mem_addr,
  output logic [WORD_WIDTH-1:0] mem_wdata,
  input  logic                  mem_resp,
  input  logic [WORD_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam int TW_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int TW     = (TW_RAW < 1) ? 1 : TW_RAW;
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TIMER_MAX  = {TW{1'b1}};

  state_e                state_q, state_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic                  mem_read_q, mem_read_d;
  logic                  mem_write_q, mem_write_d;
  logic [WORD_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [WORD_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_error_q, rsp_error_d;
  logic [WORD_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

  // Next-state and registered-output decode
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rsp_valid_d = 1'b0;
    rsp_error_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          mem_addr_d  = req_addr;
          mem_wdata_d = req_wdata;
          mem_write_d = req_write;
          mem_read_d  = ~req_write;
          timer_d     = '0;
          state_d     = ACCESS;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        // A response landing on the last allowed cycle still wins over the timeout
        if (mem_resp) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          rsp_valid_d = 1'b1;
          if (mem_read_q) begin
            rsp_rdata_d = mem_rdata;
          end else begin
            rsp_rdata_d = rsp_rdata_q;
          end
          state_d = RESP;
        end else if (TIMEOUT_EN && (timer_q == TIMER_LAST)) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_error_d = 1'b1;
          if (mem_read_q) begin
            rsp_rdata_d = '0;
          end else begin
            rsp_rdata_d = rsp_rdata_q;
          end
          state_d = RESP;
        end else if (timer_q != TIMER_MAX) begin
          timer_d = timer_q + TW'(1);
        end else begin
          timer_d = timer_q;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d     = IDLE;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_error_q <= rsp_error_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_error = rsp_error_q;
  assign rsp_rdata = rsp_rdata_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule
